// File: rtl/pov_spi_rx_if.sv
// Point-of-view SPI receiver bundle: host-side SPI/tick inputs
// and the committed fixed-point view record with status flags.
interface pov_spi_rx_if #(
    parameter int QM = 6,
    parameter int QN = 10
);
    localparam int W = QM + QN;

    logic         sclk;
    logic         ss_n;
    logic         mosi;
    logic         tick;
    logic [W-1:0] playerX;
    logic [W-1:0] playerY;
    logic [W-1:0] facingX;
    logic [W-1:0] facingY;
    logic [W-1:0] vplaneX;
    logic [W-1:0] vplaneY;
    logic         pov_load;
    logic         pov_pending;
    logic         busy;
    logic         frame_err;

    modport master (
        output sclk, ss_n, mosi, tick,
        input  playerX, playerY, facingX, facingY, vplaneX, vplaneY,
        input  pov_load, pov_pending, busy, frame_err
    );

    modport slave (
        input  sclk, ss_n, mosi, tick,
        output playerX, playerY, facingX, facingY, vplaneX, vplaneY,
        output pov_load, pov_pending, busy, frame_err
    );
endinterface

// File: rtl/pov_spi_rx.sv
// Mode-0 SPI slave receiving a six-word view record, double-buffered
// so a finished frame only reaches the outputs on the frame tick.
module pov_spi_rx #(
    parameter int QM = 6,
    parameter int QN = 10
) (
    input  logic          clk,
    input  logic          reset,
    pov_spi_rx_if.slave   bus
);
    localparam int W  = QM + QN;
    localparam int FW = 6 * W;
    localparam int CW = $clog2(FW + 2);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        IDLE     = 2'd1,
        SHIFT    = 2'd2
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [2:0]    sclk_q;
    logic [1:0]    ss_q;
    logic [1:0]    mosi_q;
    logic [FW-1:0] shift;
    logic [CW-1:0] bitcnt;
    logic [FW-1:0] pend;
    logic          pend_v;
    logic [FW-1:0] pov;
    logic          load_q;

    logic ss_hi;
    logic sclk_rise;
    logic busy;
    logic shift_en;
    logic frame_ok;
    logic frame_bad;

    assign ss_hi     = ss_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];

    // ss_n sync resets low so the host must be seen idle before arming
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sclk};
            ss_q   <= {ss_q[0], bus.ss_n};
            mosi_q <= {mosi_q[0], bus.mosi};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= DISARMED;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            DISARMED: if (ss_hi)  nxt = IDLE;
            IDLE:     if (!ss_hi) nxt = SHIFT;
            SHIFT:    if (ss_hi)  nxt = IDLE;
            default:              nxt = DISARMED;
        endcase
    end

    always_comb begin
        busy      = (state == SHIFT);
        shift_en  = busy & ~ss_hi & sclk_rise;
        frame_ok  = busy & ss_hi & (bitcnt == CW'(FW));
        frame_bad = busy & ss_hi & (bitcnt != CW'(FW));
    end

    // Commit reads the old buffer; a frame finishing on the same edge waits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift  <= '0;
            bitcnt <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            pov    <= '0;
            load_q <= 1'b0;
        end else begin
            load_q <= bus.tick & pend_v;
            if (bus.tick && pend_v) begin
                pov    <= pend;
                pend_v <= 1'b0;
            end
            if (frame_ok) begin
                pend   <= shift;
                pend_v <= 1'b1;
            end
            if (state == IDLE) begin
                bitcnt <= '0;
            end else if (shift_en) begin
                shift <= {shift[FW-2:0], mosi_q[1]};
                if (bitcnt != CW'(FW + 1))
                    bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    assign bus.playerX     = pov[6*W-1 -: W];
    assign bus.playerY     = pov[5*W-1 -: W];
    assign bus.facingX     = pov[4*W-1 -: W];
    assign bus.facingY     = pov[3*W-1 -: W];
    assign bus.vplaneX     = pov[2*W-1 -: W];
    assign bus.vplaneY     = pov[W-1 -: W];
    assign bus.pov_load    = load_q;
    assign bus.pov_pending = pend_v;
    assign bus.busy        = busy;
    assign bus.frame_err   = frame_bad;
endmodule

// File: tb/tb_pov_spi_rx.sv
// Bench for pov_spi_rx: vector table, random frames against a
// bit-queue model, and hand-written reset/alignment sequences.
module tb_pov_spi_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;

    pov_spi_rx_if #(.QM(6), .QN(10)) bus ();

    pov_spi_rx #(.QM(6), .QN(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int pass = 0;
    int err_cnt = 0;
    int load_cnt = 0;

    always @(negedge clk) begin
        if (bus.frame_err) err_cnt++;
        if (bus.pov_load)  load_cnt++;
    end

    logic [95:0] m_out = '0;
    logic [95:0] m_pend = '0;
    bit          m_pv = 0;
    bit          q[$];

    function automatic int m_end();
        int n;
        logic [95:0] v;
        n = q.size();
        if (n == 96) begin
            v = '0;
            foreach (q[i]) v[95-i] = q[i];
            m_pend = v;
            m_pv = 1;
        end
        q.delete();
        return (n == 96) ? 0 : 1;
    endfunction

    function automatic int m_tick();
        if (m_pv) begin
            m_out = m_pend;
            m_pv = 0;
            return 1;
        end
        return 0;
    endfunction

    function automatic logic [95:0] outs();
        return {bus.playerX, bus.playerY, bus.facingX,
                bus.facingY, bus.vplaneX, bus.vplaneY};
    endfunction

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic sbit(input logic b);
        bus.mosi = b;
        #40;
        bus.sclk = 1'b1;
        #40;
        bus.sclk = 1'b0;
    endtask

    task automatic send(input int n, input logic [95:0] d);
        logic b;
        bus.ss_n = 1'b0;
        #60;
        for (int i = 0; i < n; i++) begin
            b = (i < 96) ? d[95-i] : 1'($urandom_range(0, 1));
            sbit(b);
            q.push_back(b);
        end
        #40;
    endtask

    int exp_err;
    int exp_ld;

    task automatic end_frame();
        bus.ss_n = 1'b1;
        exp_err = m_end();
        #100;
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        exp_ld = m_tick();
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
    endtask

    // ss_n high lands in sync flop 1 at edge 1; completion is edge 3
    task automatic end_aligned();
        @(negedge clk);
        bus.ss_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.tick = 1'b1;
        exp_ld = m_tick();
        exp_err = m_end();
        @(negedge clk);
        bus.tick = 1'b0;
        #100;
    endtask

    typedef struct {
        int          nbits;
        logic [95:0] data;
        bit          tick_after;
        int          e_err;
        int          e_loads;
        bit          e_pend;
        logic [95:0] e_out;
    } vec_t;

    localparam logic [95:0] F1 =
        {16'h0600, 16'h2E00, 16'h0000, 16'hFC00, 16'h0200, 16'h0000};
    localparam logic [95:0] FA =
        {16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    localparam logic [95:0] FB =
        {16'h0200, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};

    vec_t vecs[5];
    int e0, l0;
    bit bad;
    logic [95:0] fc, fd, rd;
    int n;
    bit tk;

    initial begin
        vecs[0] = '{96, F1, 1'b1, 0, 1, 1'b0, F1};
        vecs[1] = '{95, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 1'b0, 1, 0, 1'b0, F1};
        vecs[2] = '{97, 96'h0F0F_F0F0_5555_AAAA_1234_5678, 1'b0, 1, 0, 1'b0, F1};
        vecs[3] = '{96, FA, 1'b0, 0, 0, 1'b1, F1};
        vecs[4] = '{96, FB, 1'b1, 0, 1, 1'b0, FB};

        bus.sclk = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tick = 1'b0;
        #22;
        chk("reset_out", outs(), '0);
        chk("reset_pend", bus.pov_pending, 0);
        chk("reset_busy", bus.busy, 0);
        reset = 1'b0;
        #100;

        foreach (vecs[k]) begin
            e0 = err_cnt;
            l0 = load_cnt;
            send(vecs[k].nbits, vecs[k].data);
            chk($sformatf("v%0d_busy", k), bus.busy, 1);
            end_frame();
            if (vecs[k].tick_after) do_tick();
            chk($sformatf("v%0d_err", k), err_cnt - e0, vecs[k].e_err);
            chk($sformatf("v%0d_loads", k), load_cnt - l0, vecs[k].e_loads);
            chk($sformatf("v%0d_pend", k), bus.pov_pending, vecs[k].e_pend);
            chk($sformatf("v%0d_out", k), outs(), vecs[k].e_out);
        end

        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 4))
                0: n = 95;
                1: n = 97;
                default: n = 96;
            endcase
            rd = {$urandom, $urandom, $urandom};
            tk = 1'($urandom_range(0, 1));
            e0 = err_cnt;
            l0 = load_cnt;
            send(n, rd);
            end_frame();
            chk($sformatf("r%0d_err", r), err_cnt - e0, exp_err);
            exp_ld = 0;
            if (tk) do_tick();
            chk($sformatf("r%0d_loads", r), load_cnt - l0, exp_ld);
            chk($sformatf("r%0d_pend", r), bus.pov_pending, m_pv);
            chk($sformatf("r%0d_out", r), outs(), m_out);
        end
        if (m_pv) do_tick();

        // hold off tick: outputs frozen while pending
        rd = {$urandom, $urandom, $urandom};
        l0 = load_cnt;
        send(96, rd);
        end_frame();
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (outs() !== m_out || bus.pov_pending !== 1'b1) bad = 1;
        end
        chk("hold_stable", bad, 0);
        chk("hold_noload", load_cnt - l0, 0);
        do_tick();
        chk("hold_commit", outs(), rd);
        chk("hold_pend0", bus.pov_pending, 0);
        chk("hold_load1", load_cnt - l0, 1);

        // completion on the tick edge with an older frame pending
        fc = {$urandom, $urandom, $urandom};
        fd = {$urandom, $urandom, $urandom};
        send(96, fc);
        end_frame();
        l0 = load_cnt;
        send(96, fd);
        end_aligned();
        chk("align_load", load_cnt - l0, 1);
        chk("align_outC", outs(), fc);
        chk("align_pend", bus.pov_pending, 1);
        do_tick();
        chk("align_outD", outs(), fd);
        chk("align_pend0", bus.pov_pending, 0);

        // reset mid-frame, ss_n still low afterwards
        rd = {$urandom, $urandom, $urandom};
        bus.ss_n = 1'b0;
        #60;
        for (int i = 0; i < 40; i++) sbit(rd[95-i]);
        reset = 1'b1;
        q.delete();
        m_out = '0;
        m_pv = 0;
        #25;
        chk("rst_out", outs(), '0);
        reset = 1'b0;
        e0 = err_cnt;
        for (int i = 40; i < 96; i++) sbit(rd[95-i]);
        #40;
        bus.ss_n = 1'b1;
        #100;
        chk("rst_noerr", err_cnt - e0, 0);
        chk("rst_nopend", bus.pov_pending, 0);
        chk("rst_busy", bus.busy, 0);
        fd = {$urandom, $urandom, $urandom};
        send(96, fd);
        end_frame();
        chk("rst_pend", bus.pov_pending, 1);
        do_tick();
        chk("rst_out2", outs(), fd);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
